// File: rtl/overlay_config_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | overlay_config_loader_if                                                 |
// | Byte-stream input and shift-chain/status outputs of the config loader.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface overlay_config_loader_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   start;
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   shift_enable;
  logic                   shift_data;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [COUNT_WIDTH-1:0] bits_loaded;

  modport master (
    output start, byte_valid, byte_data,
    input  shift_enable, shift_data, busy, done, error, bits_loaded
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output shift_enable, shift_data, busy, done, error, bits_loaded
  );
endinterface
`default_nettype wire

// File: rtl/overlay_config_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | overlay_config_loader                                                    |
// | Shifts CHAIN_LENGTH bits, LSB-first from a byte stream, into the overlay |
// | configuration chain. CONFIG_CHECKSUM_EN adds a trailing sum-byte check.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module overlay_config_loader #(
  parameter int CHAIN_LENGTH = 100,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  overlay_config_loader_if.slave cfg
);

  localparam logic [COUNT_WIDTH-1:0] c_chain_length = COUNT_WIDTH'(CHAIN_LENGTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_SHIFT     = 3'd2,
`ifdef CONFIG_CHECKSUM_EN
    ST_CHECK     = 3'd3,
`endif
    ST_FINISH    = 3'd4
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_shreg;
  logic [2:0]             r_idx;
  logic                   r_shift_enable;
  logic                   r_shift_data;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic [COUNT_WIDTH-1:0] r_bits_loaded;
`ifdef CONFIG_CHECKSUM_EN
  logic [7:0]             r_sum;
`endif

  logic [COUNT_WIDTH-1:0] w_bits_next;

  // Saturating count of bits consumed by the chain, including this cycle's bit.
  assign w_bits_next = (r_bits_loaded == c_chain_length) ? r_bits_loaded
                                                         : r_bits_loaded + COUNT_WIDTH'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_shreg        <= 8'h00;
      r_idx          <= 3'd0;
      r_shift_enable <= 1'b0;
      r_shift_data   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_bits_loaded  <= '0;
`ifdef CONFIG_CHECKSUM_EN
      r_sum          <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg.start) begin
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_bits_loaded <= '0;
`ifdef CONFIG_CHECKSUM_EN
            r_sum         <= 8'h00;
`endif
            r_state       <= ST_WAIT_BYTE;
          end
        end

        ST_WAIT_BYTE: begin
          if (cfg.byte_valid) begin
            r_shreg        <= cfg.byte_data;
            r_idx          <= 3'd0;
            r_shift_enable <= 1'b1;
            r_shift_data   <= cfg.byte_data[0];
`ifdef CONFIG_CHECKSUM_EN
            r_sum          <= r_sum + cfg.byte_data;
`endif
            r_state        <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // The bit presented this cycle is taken by the chain at this edge.
          r_bits_loaded <= w_bits_next;
          r_idx         <= r_idx + 3'd1;
          r_shreg       <= {1'b0, r_shreg[7:1]};
          r_shift_data  <= r_shreg[1];
          if (cfg.byte_valid) begin
            r_shift_enable <= 1'b0;
            r_shift_data   <= 1'b0;
            r_error        <= 1'b1;
            r_state        <= ST_FINISH;
          end else if (w_bits_next == c_chain_length) begin
            r_shift_enable <= 1'b0;
            r_shift_data   <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
            r_state        <= ST_CHECK;
`else
            r_state        <= ST_FINISH;
`endif
          end else if (r_idx == 3'd7) begin
            r_shift_enable <= 1'b0;
            r_shift_data   <= 1'b0;
            r_state        <= ST_WAIT_BYTE;
          end
        end

`ifdef CONFIG_CHECKSUM_EN
        ST_CHECK: begin
          if (cfg.byte_valid) begin
            r_error <= (cfg.byte_data != r_sum);
            r_state <= ST_FINISH;
          end
        end
`endif

        ST_FINISH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg.shift_enable = r_shift_enable;
  assign cfg.shift_data   = r_shift_data;
  assign cfg.busy         = r_busy;
  assign cfg.done         = r_done;
  assign cfg.error        = r_error;
  assign cfg.bits_loaded  = r_bits_loaded;

endmodule
`default_nettype wire

// File: tb/tb_overlay_config_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_overlay_config_loader                                                 |
// | Randomized scoreboard bench for overlay_config_loader (12- and 8-bit).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_overlay_config_loader;

  localparam int CL = 12;
  localparam int CW = 16;
`ifdef CONFIG_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  overlay_config_loader_if #(.COUNT_WIDTH(CW)) bus ();
  overlay_config_loader_if #(.COUNT_WIDTH(CW)) bus8 ();

  overlay_config_loader #(.CHAIN_LENGTH(CL), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .cfg(bus)
  );
  overlay_config_loader #(.CHAIN_LENGTH(8), .COUNT_WIDTH(CW)) dut8 (
    .clock(clock), .reset(reset), .cfg(bus8)
  );

  typedef struct { bit err; int nbits; } res_t;

  bit         exp_bits[$];
  res_t       exp_res[$];
  logic [7:0] sd[$];
  int         sg[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       prev_done = 1'b0;
  int         shifts8 = 0;
  int         ones8   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT shifts a bit or reports done.
  always @(negedge clock) begin
    res_t r;
    if (reset) begin
      if (bus.shift_enable) begin
        chk("busy_during_shift", bus.busy, 1);
        chk("shift_expected", exp_bits.size() > 0, 1);
        if (exp_bits.size() > 0) chk("shift_data", bus.shift_data, exp_bits.pop_front());
      end
      if (bus.done && !prev_done) begin
        chk("done_expected", exp_res.size() > 0, 1);
        if (exp_res.size() > 0) begin
          r = exp_res.pop_front();
          chk("error", bus.error, r.err);
          chk("bits_loaded", bus.bits_loaded, r.nbits);
          chk("busy_at_done", bus.busy, 0);
        end
      end
      if (bus8.shift_enable) begin
        shifts8 <= shifts8 + 1;
        ones8   <= ones8 + int'(bus8.shift_data);
      end
    end
    prev_done <= bus.done;
  end

  task automatic add(input logic [7:0] b, input int gap);
    sd.push_back(b);
    sg.push_back(gap);
  endtask

  // Reference: byte i arrives sg[i] cycles after the previous event (start for i=0).
  // A byte accepted at edge E shifts its bits in the following min(8, remaining) cycles;
  // a byte landing inside that window is an overrun after sg[i] of those bits.
  function automatic void push_model();
    int         loaded  = 0;
    int         pending = 0;
    bit         fin     = 1'b0;
    bit         waitck  = 1'b0;
    bit         err     = 1'b0;
    logic [7:0] sum     = 8'h00;
    logic [7:0] cur     = 8'h00;
    res_t       r;
    for (int i = 0; i < sd.size(); i++) begin
      if (fin) continue;
      if (pending > 0) begin
        int k = (sg[i] <= pending) ? sg[i] : pending;
        for (int b = 0; b < k; b++) exp_bits.push_back(cur[b]);
        loaded += k;
        if (sg[i] <= pending) begin
          err = 1'b1;
          fin = 1'b1;
          continue;
        end
        pending = 0;
        if (loaded == CL) begin
          if (CK) waitck = 1'b1;
          else begin
            fin = 1'b1;
            continue;
          end
        end
      end
      if (waitck) begin
        err = (sd[i] != sum);
        fin = 1'b1;
        continue;
      end
      sum     = sum + sd[i];
      cur     = sd[i];
      pending = (CL - loaded < 8) ? CL - loaded : 8;
    end
    if (!fin && pending > 0) begin
      for (int b = 0; b < pending; b++) exp_bits.push_back(cur[b]);
      loaded += pending;
    end
    r.err   = err;
    r.nbits = loaded;
    exp_res.push_back(r);
  endfunction

  task automatic wait_done();
    int c = 0;
    while (!(bus.done && !bus.busy) && c < 300) begin
      @(posedge clock);
      #1;
      c++;
    end
    chk("load_completes", c < 300, 1);
    repeat (2) @(posedge clock);
  endtask

  // noise: a byte rides along with the start pulse and start rides along with every byte.
  task automatic drive(input bit noise);
    push_model();
    @(posedge clock); #1;
    bus.start = 1'b1; bus.byte_valid = noise; bus.byte_data = 8'hFF;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.byte_valid = 1'b0;
    for (int i = 0; i < sd.size(); i++) begin
      repeat (sg[i] - 1) @(posedge clock);
      #1;
      bus.byte_valid = 1'b1; bus.byte_data = sd[i]; bus.start = noise;
      @(posedge clock); #1;
      bus.byte_valid = 1'b0; bus.start = 1'b0;
    end
    wait_done();
    sd.delete();
    sg.delete();
  endtask

  task automatic random_load();
    int         nb    = (CL + 7) / 8 + int'(CK);
    bit         ovr   = ($urandom_range(0, 3) == 0);
    bit         noise = !ovr && ($urandom_range(0, 1) == 1);
    int         at    = $urandom_range(1, nb - 1);
    logic [7:0] sum   = 8'h00;
    logic [7:0] b;
    int         gap;
    for (int i = 0; i < nb; i++) begin
      b   = 8'($urandom);
      gap = (i == 0) ? $urandom_range(1, 5) : $urandom_range(9, 13);
      if (ovr && i == at) gap = $urandom_range(1, 4);
      if (CK && i == nb - 1) b = ($urandom_range(0, 1) == 1) ? sum : (sum ^ 8'(1 << $urandom_range(0, 7)));
      sum = sum + b;
      add(b, gap);
    end
    drive(noise);
  endtask

  initial begin
    bus.start = 1'b0;  bus.byte_valid = 1'b0;  bus.byte_data = 8'h00;
    bus8.start = 1'b0; bus8.byte_valid = 1'b0; bus8.byte_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_shift_enable", bus.shift_enable, 0);
    chk("rst_shift_data", bus.shift_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_bits_loaded", bus.bits_loaded, 0);
    reset = 1'b1;

    // Nominal two-byte load: 1,0,1,0,0,1,0,1,0,0,1,1
    add(8'hA5, 2); add(8'h3C, 10);
    if (CK) add(8'hE1, 10);
    drive(1'b0);
    chk("nominal_bits_loaded", bus.bits_loaded, CL);

    // Bad checksum (only meaningful with the checksum feature)
    if (CK) begin
      add(8'hA5, 2); add(8'h3C, 10); add(8'hE0, 10);
      drive(1'b0);
    end

    // Overrun two cycles into the first byte
    add(8'hA5, 2); add(8'h3C, 2);
    if (CK) add(8'hE1, 10);
    drive(1'b0);
    chk("overrun_error", bus.error, 1);

    // Stray byte while idle, then a load with spurious start/byte pulses
    @(posedge clock); #1; bus.byte_valid = 1'b1; bus.byte_data = 8'h55;
    @(posedge clock); #1; bus.byte_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_byte_ignored", bus.busy, 0);
    add(8'h5A, 3); add(8'hC3, 11);
    if (CK) add(8'h1D, 9);
    drive(1'b1);

    // Reset during the third shift of the first byte
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b0);
    @(posedge clock); #1; bus.start = 1'b1;
    @(posedge clock); #1; bus.start = 1'b0;
    #1; bus.byte_valid = 1'b1; bus.byte_data = 8'hA5;
    @(posedge clock); #1; bus.byte_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2; reset = 1'b0;
    #1;
    chk("mid_rst_shift_enable", bus.shift_enable, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_error", bus.error, 0);
    chk("mid_rst_bits_loaded", bus.bits_loaded, 0);
    chk("mid_rst_bits_consumed", exp_bits.size(), 0);
    @(posedge clock); #1; reset = 1'b1;
    add(8'h96, 1); add(8'h0F, 12);
    if (CK) add(8'hA5, 10);
    drive(1'b0);

    repeat (20) random_load();

    // Chain length 8: one full byte, then a trailing byte that must never shift
    @(posedge clock); #1; bus8.start = 1'b1;
    @(posedge clock); #1; bus8.start = 1'b0;
    #1; bus8.byte_valid = 1'b1; bus8.byte_data = 8'hFF;
    @(posedge clock); #1; bus8.byte_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1; bus8.byte_valid = 1'b1; bus8.byte_data = 8'hFF;
    @(posedge clock); #1; bus8.byte_valid = 1'b0;
    begin
      int c = 0;
      while (!(bus8.done && !bus8.busy) && c < 100) begin
        @(posedge clock); #1; c++;
      end
      chk("len8_completes", c < 100, 1);
    end
    repeat (12) @(posedge clock);
    #1;
    chk("len8_shift_count", shifts8, 8);
    chk("len8_ones", ones8, 8);
    chk("len8_bits_loaded", bus8.bits_loaded, 8);
    chk("len8_error", bus8.error, 0);
    chk("len8_done", bus8.done, 1);

    chk("leftover_bits", exp_bits.size(), 0);
    chk("leftover_results", exp_res.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
